transport_receive: RTL and testbench

TRANSPORT_RECEIVE -- requirements
Module: transport_receive

---
 rtl/transport_receive.sv | 171 +++++++++++++++++
 tb/tb_transport_receive.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transport_receive.sv
// Transport-layer receiver.
// Pulls bytes one at a time from the network receive buffer and checks the
// packet header. Good packets are split into 16-bit payload words that are
// handed to a ready/valid consumer. Packets with a bad header are read to
// their end, thrown away and counted.
module transport_receive #(
  parameter int         packetSize = 16,
  parameter logic [3:0] MAGIC      = 4'hA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  netData,
  input  logic        netEmpty,
  output logic        netRd,
  output logic [15:0] dataOut,
  output logic [1:0]  cmdOut,
  output logic [7:0]  phoneNum,
  output logic        dataValid,
  input  logic        dataReady,
  output logic        packetDone,
  output logic        busy,
  output logic [7:0]  dropCount
);

  // Stop elaboration on a packet length that cannot hold a header, a source
  // byte and whole payload words.
  if ((packetSize < 4) || ((packetSize % 2) != 0)) begin : g_bad_packet_size
    $error("transport_receive: packetSize must be even and >= 4");
  end

  localparam int                CNT_W    = $clog2(packetSize);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(packetSize - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_SRC    = 3'd2;
  localparam logic [2:0] S_PAY_HI = 3'd3;
  localparam logic [2:0] S_PAY_LO = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;
  localparam logic [2:0] S_DROP   = 3'd6;

  logic [2:0]       r_state;
  logic             r_pend;      // a read was issued last cycle; its byte is on netData now
  logic [CNT_W-1:0] r_cnt;       // index of the next byte of the packet to capture
  logic             r_last;      // the word held in OUT is the last of its packet
  logic [15:0]      r_data;
  logic [1:0]       r_cmd;
  logic [7:0]       r_phone;
  logic             r_valid;
  logic             r_done;
  logic [7:0]       r_drop;

  logic w_reading;
  logic w_issue;
  logic w_cap;
  logic w_last_byte;
  logic w_accept;
  logic w_hdr_ok;

  // OUT is the only state that does not read bytes from the network buffer.
  assign w_reading   = (r_state != S_OUT) && (r_state != 3'd7);
  // Only one read may be in flight. No read is issued while a word is still
  // waiting for the consumer.
  assign w_issue     = w_reading && !netEmpty && !r_pend && !r_valid;
  assign w_cap       = r_pend;
  assign w_last_byte = (r_cnt == LAST_IDX);
  assign w_accept    = r_valid && dataReady;
  assign w_hdr_ok    = (netData[7:4] == MAGIC) && (netData[3:2] == 2'b00);

  // The strobe is combinational so that it follows netEmpty in the same
  // cycle. It is gated by reset so that it stays low while reset is held.
  assign netRd      = reset & w_issue;

  assign dataOut    = r_data;
  assign cmdOut     = r_cmd;
  assign phoneNum   = r_phone;
  assign dataValid  = r_valid;
  assign packetDone = r_done;
  assign busy       = (r_state != S_IDLE);
  assign dropCount  = r_drop;

  // Track the outstanding read and count the bytes captured in each packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= 1'b0;
      r_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All flops then
      // sample values from before the edge, whatever order the blocks run in.
      r_pend <= w_issue;
      if (w_cap) begin
        r_cnt <= w_last_byte ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end

  // Packet FSM: header check, source capture, word assembly and handoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b0;
      r_data  <= 16'h0000;
      r_cmd   <= 2'b00;
      r_phone <= 8'h00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_drop  <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_cap) begin
            if (w_hdr_ok) begin
              r_cmd   <= netData[1:0];
              r_state <= S_SRC;
            end else begin
              if (r_drop != 8'hFF) begin
                r_drop <= r_drop + 8'd1;
              end
              r_state <= S_DROP;
            end
          end
        end
        S_SRC: begin
          if (w_cap) begin
            r_phone <= netData;
            r_state <= S_PAY_HI;
          end
        end
        S_PAY_HI: begin
          if (w_cap) begin
            r_data[15:8] <= netData;
            r_state      <= S_PAY_LO;
          end
        end
        S_PAY_LO: begin
          // The word is offered on the same edge that captures its low byte.
          if (w_cap) begin
            r_data[7:0] <= netData;
            r_valid     <= 1'b1;
            r_last      <= w_last_byte;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_PAY_HI;
            end
          end
        end
        S_DROP: begin
          if (w_cap && w_last_byte) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transport_receive.sv
// Self-checking bench for transport_receive.
// A queue models the network receive buffer. A reference model works out
// the words each packet should produce and the drop count from the packet
// format rules. The consumer side is checked every cycle against that model.
module tb_transport_receive;

  localparam int         PKT   = 16;
  localparam logic [3:0] MAGIC = 4'hA;
  localparam int         NW    = (PKT - 2) / 2;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  ph;
    logic [15:0] data;
    bit          last;
    int          idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  netData;
  logic        netEmpty;
  logic        netRd;
  logic [15:0] dataOut;
  logic [1:0]  cmdOut;
  logic [7:0]  phoneNum;
  logic        dataValid;
  logic        dataReady;
  logic        packetDone;
  logic        busy;
  logic [7:0]  dropCount;

  transport_receive #(.packetSize(PKT), .MAGIC(MAGIC)) dut (
    .clk        (clk),
    .reset      (reset),
    .netData    (netData),
    .netEmpty   (netEmpty),
    .netRd      (netRd),
    .dataOut    (dataOut),
    .cmdOut     (cmdOut),
    .phoneNum   (phoneNum),
    .dataValid  (dataValid),
    .dataReady  (dataReady),
    .packetDone (packetDone),
    .busy       (busy),
    .dropCount  (dropCount)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;

  bq_t  q_net;
  exp_t exp_q[$];
  int   exp_drop   = 0;
  int   pop_total  = 0;
  int   hs_count   = 0;
  int   done_count = 0;
  bit   rd_seen    = 1'b0;
  bit   done_exp   = 1'b0;
  bit   stall_prev = 1'b0;
  logic [15:0] held_data;
  exp_t mon_e;

  int   ready_mode = 0;     // 0: always ready, 1: random, 2: hold off word index 2
  int   stall_cnt  = 0;
  bit   gap_mode   = 1'b0;  // netEmpty forced high every other cycle
  bit   gap_tog    = 1'b0;
  bit   rand_empty = 1'b0;  // random netEmpty bubbles

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue the bytes and derive what the consumer must see.
  task automatic push_packet(input bq_t p);
    logic [7:0] h;
    h = p[0];
    if ((h[7:4] == MAGIC) && (h[3:2] == 2'b00)) begin
      for (int w = 0; w < NW; w++) begin
        exp_t e;
        e.cmd  = h[1:0];
        e.ph   = p[1];
        e.data = {p[2 + 2*w], p[3 + 2*w]};
        e.last = (w == NW - 1);
        e.idx  = w;
        exp_q.push_back(e);
      end
    end else begin
      exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
    end
    foreach (p[i]) q_net.push_back(p[i]);
  endtask

  task automatic rand_packet(input bit good, output bq_t p);
    logic [7:0] h;
    p = {};
    if (good) begin
      h = {MAGIC, 2'b00, 2'($urandom_range(3))};
    end else begin
      do h = 8'($urandom_range(255));
      while ((h[7:4] == MAGIC) && (h[3:2] == 2'b00));
    end
    p.push_back(h);
    for (int i = 1; i < PKT; i++) p.push_back(8'($urandom_range(255)));
  endtask

  task automatic drain(input string tag, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (q_net.size() == 0 && exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_netRd"},      netRd,      0);
    check({tag, "_dataValid"},  dataValid,  0);
    check({tag, "_packetDone"}, packetDone, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_dataOut"},    dataOut,    0);
    check({tag, "_cmdOut"},     cmdOut,     0);
    check({tag, "_phoneNum"},   phoneNum,   0);
    check({tag, "_dropCount"},  dropCount,  0);
  endtask

  // Buffer and consumer drivers: act just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rd_seen) begin
      if (q_net.size() == 0) begin
        check("read_of_empty_buffer", 1, 0);
      end else begin
        netData = q_net.pop_front();
        pop_total++;
      end
    end
    gap_tog  = ~gap_tog;
    netEmpty = (q_net.size() == 0) || (gap_mode && gap_tog) ||
               (rand_empty && ($urandom_range(2) == 0));
    case (ready_mode)
      0: dataReady = 1'b1;
      1: dataReady = ($urandom_range(2) != 0);
      default: begin
        if (dataValid && exp_q.size() > 0 && exp_q[0].idx == 2 && stall_cnt < 10) begin
          dataReady = 1'b0;
          stall_cnt++;
        end else begin
          dataReady = 1'b1;
        end
      end
    endcase
  end

  // Monitor: protocol, handshake and packetDone checks between edges.
  always @(negedge clk) begin
    rd_seen = netRd;
    if (reset) begin
      check("rd_protocol", netRd & (netEmpty | dataValid), 0);
      check("packet_done", packetDone, done_exp);
      if (packetDone) done_count++;
      done_exp = 1'b0;
      if (stall_prev) check("hold_data", dataOut, held_data);
      stall_prev = 1'b0;
      if (dataValid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else if (dataReady) begin
          mon_e = exp_q.pop_front();
          check("word_data",  dataOut,  mon_e.data);
          check("word_cmd",   cmdOut,   mon_e.cmd);
          check("word_phone", phoneNum, mon_e.ph);
          done_exp = mon_e.last;
          hs_count++;
        end else begin
          stall_prev = 1'b1;
          held_data  = dataOut;
        end
      end
    end else begin
      done_exp   = 1'b0;
      stall_prev = 1'b0;
    end
  end

  initial begin
    bq_t p;
    int  hs0, dn0, base;
    bit  hit;

    reset     = 1'b0;
    netEmpty  = 1'b1;
    netData   = 8'h00;
    dataReady = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_init");
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed good packet with a continuously ready consumer.
    hs0 = hs_count; dn0 = done_count;
    p = '{8'hA2, 8'h37, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC,
          8'hDE, 8'hF0, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};
    push_packet(p);
    drain("good_drain", 500);
    check("good_handshakes", hs_count - hs0, NW);
    check("good_done_pulses", done_count - dn0, 1);
    check("good_cmd_hold", cmdOut, 2'd2);
    check("good_phone_hold", phoneNum, 8'h37);
    check("good_drop", dropCount, exp_drop);

    // Bad header followed by a good packet.
    p = {8'h52};
    for (int i = 1; i < PKT; i++) p.push_back(8'(i * 17));
    push_packet(p);
    hs0 = hs_count;
    p = '{8'hA1, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
          8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
    push_packet(p);
    drain("bad_then_good_drain", 800);
    check("bad_drop_count", dropCount, 1);
    check("bad_then_good_handshakes", hs_count - hs0, NW);

    // Consumer stalls on the third word of a packet.
    ready_mode = 2; stall_cnt = 0; hs0 = hs_count;
    rand_packet(1'b1, p);
    push_packet(p);
    drain("stall_drain", 800);
    check("stall_handshakes", hs_count - hs0, NW);
    check("stall_cycles", stall_cnt, 10);
    ready_mode = 0;

    // netEmpty toggling every other cycle.
    gap_mode = 1'b1; hs0 = hs_count;
    rand_packet(1'b1, p);
    push_packet(p);
    drain("gap_drain", 1000);
    check("gap_handshakes", hs_count - hs0, NW);
    gap_mode = 1'b0;

    // Randomized traffic: mixed headers, bubbles and consumer back-pressure.
    rand_empty = 1'b1; ready_mode = 1;
    for (int k = 0; k < 24; k++) begin
      rand_packet($urandom_range(3) != 0, p);
      push_packet(p);
    end
    drain("random_drain", 8000);
    check("random_drop", dropCount, exp_drop);
    rand_empty = 1'b0; ready_mode = 0;

    // Reset while the low byte of word 4 is being fetched.
    rand_packet(1'b1, p);
    base = pop_total;
    push_packet(p);
    hit = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #2;
      if (pop_total - base >= 10) begin
        hit = 1'b1;
        break;
      end
    end
    check("reset_reach_word4", hit, 1'b1);
    reset = 1'b0;
    q_net.delete();
    exp_q.delete();
    exp_drop = 0;
    @(negedge clk);
    check_reset_outputs("reset_mid");
    @(posedge clk); #2 reset = 1'b1;
    hs0 = hs_count; dn0 = done_count;
    p = '{8'hA3, 8'h42, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h11, 8'h22,
          8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
    push_packet(p);
    drain("post_reset_drain", 500);
    check("post_reset_handshakes", hs_count - hs0, NW);
    check("post_reset_done", done_count - dn0, 1);
    check("post_reset_cmd", cmdOut, 2'd3);
    check("post_reset_phone", phoneNum, 8'h42);

    // 256 bad headers saturate the drop counter.
    for (int k = 0; k < 256; k++) begin
      rand_packet(1'b0, p);
      push_packet(p);
    end
    drain("sat_drain", 12000);
    check("drop_saturate_model", dropCount, exp_drop);
    check("drop_saturate_ff", dropCount, 8'hFF);
    check("sat_cmd_hold", cmdOut, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
